// File: rtl/reconf_coeff_loader.sv
// rtl/reconf_coeff_loader.sv - streams FIR coefficients into the filter RAM and gates the 300 kHz sample strobe
module reconf_coeff_loader #(
  parameter int P_NUM_TAP = 33,
  parameter int P_DIV     = 40
) (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iLoadStart,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffiUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic        oEnSample_300k,
  output logic        oLoadDone
);

  localparam int CW = $clog2(P_NUM_TAP + 1);
  localparam int DW = (P_DIV > 1) ? $clog2(P_DIV) : 1;

  typedef enum logic [1:0] {
    p_Idle  = 2'd0,
    p_Write = 2'd1,
    p_Done  = 2'd2,
    p_Run   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [DW-1:0] div_cnt;
  logic          accept;
  logic          last_beat;
  logic          div_hit_next;

  // A beat lands only while writing with ready up; a restart request discards the beat offered with it.
  always_comb begin
    accept       = (state == p_Write) && oCoeffReady && iCoeffValid && !iLoadStart;
    last_beat    = (beat_cnt == CW'(P_NUM_TAP - 1));
    div_hit_next = (div_cnt == DW'(P_DIV - 2));
  end

  // Free-running sample divider, cleared only by reset so the sample grid never shifts on reloads.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(P_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // RAM write port: one strobe the cycle after each accepted beat, address and data held otherwise.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
      oAddrRam <= '0;
      oWrDtRam <= '0;
    end else if (accept) begin
      oCsnRam  <= 1'b0;
      oWrnRam  <= 1'b0;
      oAddrRam <= 6'(beat_cnt + CW'(1));
      oWrDtRam <= iCoeffData;
    end else begin
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
    end
  end

  // Load sequencing; every control output is registered from the state being entered.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state             <= p_Idle;
      beat_cnt          <= '0;
      oCoeffReady       <= 1'b0;
      oCoeffiUpdateFlag <= 1'b0;
      oLoadDone         <= 1'b0;
      oEnSample_300k    <= 1'b0;
    end else begin
      oLoadDone      <= 1'b0;
      oEnSample_300k <= 1'b0;
      case (state)
        p_Idle: begin
          if (iLoadStart) begin
            state             <= p_Write;
            beat_cnt          <= '0;
            oCoeffReady       <= 1'b1;
            oCoeffiUpdateFlag <= 1'b1;
          end
        end
        p_Write: begin
          oCoeffiUpdateFlag <= 1'b1;
          if (iLoadStart) begin
            // Restart: drop ready for one cycle so nothing offered alongside the restart lands.
            beat_cnt    <= '0;
            oCoeffReady <= 1'b0;
          end else if (accept && last_beat) begin
            state       <= p_Done;
            beat_cnt    <= beat_cnt + CW'(1);
            oCoeffReady <= 1'b0;
          end else begin
            if (accept) begin
              beat_cnt <= beat_cnt + CW'(1);
            end
            oCoeffReady <= 1'b1;
          end
        end
        p_Done: begin
          // Single cycle overlapping the final RAM strobe; load requests are ignored here.
          state             <= p_Run;
          oCoeffReady       <= 1'b0;
          oCoeffiUpdateFlag <= 1'b0;
          oLoadDone         <= 1'b1;
          oEnSample_300k    <= div_hit_next;
        end
        p_Run: begin
          if (iLoadStart) begin
            state             <= p_Write;
            beat_cnt          <= '0;
            oCoeffReady       <= 1'b1;
            oCoeffiUpdateFlag <= 1'b1;
          end else begin
            oEnSample_300k <= div_hit_next;
          end
        end
        default: begin
          state             <= p_Idle;
          oCoeffReady       <= 1'b0;
          oCoeffiUpdateFlag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reconf_coeff_loader.sv
// tb/tb_reconf_coeff_loader.sv - self-checking bench for reconf_coeff_loader
module tb_reconf_coeff_loader;

  localparam int NT  = 33;
  localparam int DIV = 40;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        ls = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        ready, upd, csn, wrn, en, done;
  logic [5:0]  addr;
  logic [15:0] wdata;

  reconf_coeff_loader #(.P_NUM_TAP(NT), .P_DIV(DIV)) dut (
    .iClk_12M(clk), .iRsn(rsn), .iLoadStart(ls), .iCoeffValid(valid), .iCoeffData(data),
    .oCoeffReady(ready), .oCoeffiUpdateFlag(upd), .oCsnRam(csn), .oWrnRam(wrn),
    .oAddrRam(addr), .oWrDtRam(wdata), .oEnSample_300k(en), .oLoadDone(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: loading/finishing/running flags, beat tally, tick count since reset
  bit          m_loading, m_finishing, m_running, m_acc;
  int          m_beats, m_ticks;
  logic        e_ready, e_upd, e_csn, e_en, e_done;
  logic [5:0]  e_addr;
  logic [15:0] e_data;

  int          strobe_cnt, done_cnt, en_cnt, last_en;
  bit          check_period;
  int          addr_q[$];

  typedef struct {
    logic rsn, ls, valid;
    logic [15:0] data;
    logic ready, csn;
    logic [5:0] addr;
    logic upd, done;
  } vec_t;
  vec_t tbl[9];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_edge();
    m_acc = 1'b0;
    if (!rsn) begin
      m_loading = 0; m_finishing = 0; m_running = 0; m_beats = 0; m_ticks = 0;
      e_ready = 0; e_upd = 0; e_csn = 1; e_addr = '0; e_data = '0; e_en = 0; e_done = 0;
      return;
    end
    m_ticks++;
    m_acc = m_loading && e_ready && valid && !ls;
    e_csn = !m_acc;
    if (m_acc) begin
      m_beats++;
      e_addr = 6'(m_beats);
      e_data = data;
    end
    e_done = 0;
    if (m_finishing) begin
      m_finishing = 0; m_running = 1; e_done = 1; e_upd = 0; e_ready = 0;
    end else if (m_loading) begin
      if (ls) begin
        m_beats = 0; e_ready = 0;
      end else if (m_acc && m_beats == NT) begin
        m_loading = 0; m_finishing = 1; e_ready = 0;
      end else begin
        e_ready = 1;
      end
      e_upd = 1;
    end else if (ls) begin
      m_loading = 1; m_running = 0; m_beats = 0; e_ready = 1; e_upd = 1;
    end
    e_en = m_running && ((m_ticks % DIV) == DIV - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("ready", ready, e_ready);
    chk("upd_flag", upd, e_upd);
    chk("csn", csn, e_csn);
    chk("wrn", wrn, e_csn);
    chk("addr", addr, e_addr);
    chk("wdata", wdata, e_data);
    chk("en_sample", en, e_en);
    chk("load_done", done, e_done);
    if (csn === 1'b0) begin
      strobe_cnt++;
      addr_q.push_back(int'(addr));
    end
    if (done === 1'b1) done_cnt++;
    if (en === 1'b1) begin
      if (check_period && last_en >= 0) chk("en_period", cyc - last_en, DIV);
      last_en = cyc;
      en_cnt++;
    end
  endtask

  task automatic clear_mon();
    strobe_cnt = 0; done_cnt = 0; en_cnt = 0; last_en = -1;
    addr_q.delete();
  endtask

  task automatic feed(input int n, input bit gap, input int base);
    int got = 0;
    int guard = 0;
    bit t = 1'b1;
    while (got < n && guard < 500) begin
      valid = gap ? t : 1'b1;
      t = !t;
      data = 16'(base + got + 1);
      step();
      if (m_acc) got++;
      guard++;
    end
    valid = 1'b0;
    if (got < n) chk("feed_timeout", got, n);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, addr_q.size(), NT);
    for (int i = 0; i < addr_q.size() && i < NT; i++) chk(name, addr_q[i], i + 1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h6666, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0};
    clear_mon();
    check_period = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rsn = tbl[i].rsn; ls = tbl[i].ls; valid = tbl[i].valid; data = tbl[i].data;
      step();
      chk("tbl_ready", ready, tbl[i].ready);
      chk("tbl_csn", csn, tbl[i].csn);
      chk("tbl_addr", addr, tbl[i].addr);
      chk("tbl_upd", upd, tbl[i].upd);
      chk("tbl_done", done, tbl[i].done);
    end

    // idle after reset
    rsn = 1'b1; ls = 1'b0; valid = 1'b0;
    clear_mon();
    repeat (200) step();
    chk("idle_en_cnt", en_cnt, 0);
    chk("idle_strobe_cnt", strobe_cnt, 0);

    // back-to-back load of 1..33
    ls = 1'b1; step(); ls = 1'b0;
    clear_mon();
    feed(NT, 1'b0, 0);
    repeat (5) step();
    check_seq("b2b_addr");
    chk("b2b_done_cnt", done_cnt, 1);
    chk("b2b_upd_low", upd, 1'b0);

    // sample strobe cadence while running
    clear_mon();
    check_period = 1'b1;
    repeat (400) step();
    check_period = 1'b0;
    chk("run_en_cnt", en_cnt, 10);

    // gapped load
    ls = 1'b1; step(); ls = 1'b0;
    clear_mon();
    feed(NT, 1'b1, 100);
    repeat (5) step();
    check_seq("gap_addr");
    chk("gap_done_cnt", done_cnt, 1);

    // restart after 10 beats
    ls = 1'b1; step(); ls = 1'b0;
    clear_mon();
    feed(10, 1'b0, 200);
    ls = 1'b1; valid = 1'b1; data = 16'hDEAD; step(); ls = 1'b0; valid = 1'b0;
    chk("restart_first_strobes", strobe_cnt, 10);
    addr_q.delete();
    chk("restart_no_done_yet", done_cnt, 0);
    feed(NT, 1'b0, 300);
    repeat (5) step();
    check_seq("restart_addr");
    chk("restart_done_cnt", done_cnt, 1);

    // reset during beat 20
    ls = 1'b1; step(); ls = 1'b0;
    feed(19, 1'b0, 400);
    rsn = 1'b0; valid = 1'b1; data = 16'h0BAD; step();
    rsn = 1'b1; valid = 1'b0;
    clear_mon();
    repeat (100) step();
    chk("rst_mid_en_cnt", en_cnt, 0);
    chk("rst_mid_strobes", strobe_cnt, 0);
    ls = 1'b1; step(); ls = 1'b0;
    feed(NT, 1'b1, 500);
    clear_mon();
    repeat (100) step();
    chk("reload_en_seen", en_cnt > 0, 1);

    // random traffic against the model
    repeat (3000) begin
      rsn = ($urandom_range(0, 499) != 0);
      ls = ($urandom_range(0, 59) == 0);
      valid = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reconf_coeff_loader.md
RECONF_COEFF_LOADER -- requirements
Module: reconf_coeff_loader

Interface
REQ-001 Parameter P_NUM_TAP, default 33, number of FIR coefficients per load (addresses 1..P_NUM_TAP).
REQ-002 Parameter P_DIV, default 40, iClk_12M cycles per sample-enable period (12 MHz / 300 kHz).
REQ-003 iClk_12M  input  1  sole clock; all logic on rising edge.
REQ-004 iRsn  input  1  synchronous active-low reset.
REQ-005 iLoadStart  input  1  one-cycle request to begin a new coefficient load.
REQ-006 iCoeffValid  input  1  iCoeffData is valid this cycle.
REQ-007 iCoeffData  input  16  signed coefficient word.
REQ-008 oCoeffReady  output  1  loader accepts a coefficient this cycle.
REQ-009 oCoeffiUpdateFlag  output  1  drives the FIR iCoeffiUpdateFlag.
REQ-010 oCsnRam  output  1  drives the FIR iCsnRam, active low.
REQ-011 oWrnRam  output  1  drives the FIR iWrnRam, active low.
REQ-012 oAddrRam  output  6  drives the FIR iAddrRam.
REQ-013 oWrDtRam  output  16  drives the FIR iWrDtRam, signed.
REQ-014 oEnSample_300k  output  1  one-cycle sample strobe to the FIR and input source.
REQ-015 oLoadDone  output  1  one-cycle pulse when a full load completes.

Function
REQ-016 The FSM SHALL have states p_Idle, p_Write, p_Done and p_Run.
REQ-017 p_Idle: entered from reset; no coefficients loaded; iLoadStart=1 -> p_Write.
REQ-018 p_Write: oCoeffReady=1 and oCoeffiUpdateFlag=1; a beat is accepted when iCoeffValid and oCoeffReady are both 1.
REQ-019 Beat counter reset to 0 on p_Write entry, +1 per accepted beat.
REQ-020 Accepted beat N (N = 1..P_NUM_TAP): the next cycle SHALL show oCsnRam=0, oWrnRam=0, oAddrRam=N, oWrDtRam=beat data, a 1-cycle write latency.
REQ-021 oCsnRam and oWrnRam SHALL be 1 in every cycle that does not follow an accepted beat; oAddrRam and oWrDtRam SHALL hold their last values.
REQ-022 iCoeffValid=0 in p_Write SHALL stall without timeout; the counter and outputs hold.
REQ-023 Accepting beat P_NUM_TAP SHALL move to p_Done; oCoeffReady is 0 from the next cycle.
REQ-024 p_Done lasts exactly 1 cycle and coincides with the final write strobe.
REQ-025 In p_Done, oCoeffiUpdateFlag=1 and oLoadDone=0; next state is p_Run.
REQ-026 In the first p_Run cycle, oLoadDone=1 and oCoeffiUpdateFlag=0.
REQ-027 p_Run with iLoadStart=1 -> p_Write.
REQ-028 iLoadStart=1 during p_Write SHALL restart the load.
REQ-029 On restart, the beat counter clears to 0 and any beat offered that cycle is discarded (oCoeffReady=0 that cycle).
REQ-030 iLoadStart in p_Done SHALL be ignored.
REQ-031 The divider counter runs 0..P_DIV-1 and wraps; it is free-running in all states and reset only by iRsn.
REQ-032 oEnSample_300k=1 only when the counter = P_DIV-1 and the state is p_Run (the registered state for that cycle); it is 0 otherwise.
REQ-033 The strobe SHALL be suppressed throughout p_Idle, p_Write and p_Done, so the FIR never samples during a coefficient update.
REQ-034 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-035 On iRsn=0 at a clock edge, the state SHALL become p_Idle and the beat and divider counters SHALL be 0.
REQ-036 Output values in reset: oCoeffReady=0, oCoeffiUpdateFlag=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oEnSample_300k=0, oLoadDone=0.
REQ-037 Reset asserted mid-load SHALL abandon the load with no further RAM strobes; p_Run requires a new complete load.

Verification
REQ-038 Reset then idle for 200 cycles -> oEnSample_300k stays 0, oCsnRam=1, oCoeffReady=0.
REQ-039 iLoadStart, then 33 back-to-back beats of data 16'h0001..16'h0021 -> 33 consecutive strobes with oAddrRam=1..33 and matching data, then oLoadDone pulses once and oCoeffiUpdateFlag falls.
REQ-040 After the load, run 400 cycles -> oEnSample_300k pulses exactly every 40 cycles, with a width of 1 cycle.
REQ-041 Gapped load with iCoeffValid toggling every cycle -> oAddrRam still steps 1..33 with no skips or duplicates; strobes only after accepted beats.
REQ-042 iLoadStart asserted after 10 beats, then 33 beats -> addresses restart at 1; oLoadDone appears only after the second run completes.
REQ-043 iRsn=0 for 1 cycle during beat 20 -> all outputs return to reset values; oEnSample_300k remains 0 until a full 33-beat load completes.
